// File: rtl/fir_sched_ctrl.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | fir_sched_ctrl: loads FIR core taps from a local coefficient file, then  |
// | issues host samples one at a time and returns the core results.          |
// | Option macro: FIR_SCHED_OVF_SAT_EN (saturate r_data on core overflow).   |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module fir_sched_ctrl #(
  parameter int MAX_TAPS = 16,
  parameter int CFG_GAP  = 2,
  parameter int TIMEOUT  = 255
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        coef_we,
  input  logic [$clog2(MAX_TAPS)-1:0] coef_addr,
  input  logic [7:0]                  coef_wdata,
  input  logic                        cfg_start,
  input  logic [$clog2(MAX_TAPS)-1:0] taps_m1,
  input  logic                        s_valid,
  output logic                        s_ready,
  input  logic [7:0]                  s_data,
  output logic                        r_valid,
  input  logic                        r_ready,
  output logic [7:0]                  r_data,
  output logic [1:0]                  r_ovf,
  output logic                        configured,
  output logic                        busy,
  output logic                        err_timeout,
  output logic [7:0]                  fir_data_in,
  output logic                        fir_enable,
  output logic                        fir_configuration,
  output logic                        fir_config_data_enable,
  input  logic [7:0]                  fir_data_out,
  input  logic [1:0]                  fir_overflow_flag,
  input  logic                        fir_done
);

  localparam int AW = $clog2(MAX_TAPS);
  localparam int TW = $clog2(TIMEOUT + 1);
  localparam int GW = $clog2(CFG_GAP + 1);
  localparam int CW = (TW > GW) ? TW : GW;

  typedef enum logic [3:0] {
    S_IDLE,
    S_READY,
    S_CFG_SETUP,
    S_CFG_COUNT,
    S_CFG_COEF,
    S_CFG_EXIT,
    S_ISSUE,
    S_WAIT_DONE,
    S_HOLD,
    S_GAP
  } state_t;

  state_t        r_state;
  state_t        w_next;
  logic [CW-1:0] r_cnt;
  logic [AW-1:0] r_idx;
  logic [AW-1:0] r_taps;
  logic [7:0]    r_sample;
  logic [7:0]    r_res_data;
  logic [1:0]    r_res_flag;
  logic          r_configured;
  logic          r_err;
  logic [7:0]    r_coef [MAX_TAPS];

  logic          w_in_cfg;
  logic          w_cfg_accept;
  logic          w_gap_last;
  logic          w_to_last;
  logic          w_coef_last;
  logic [7:0]    w_cap_data;

  assign w_in_cfg     = (r_state == S_CFG_SETUP) || (r_state == S_CFG_COUNT) ||
                        (r_state == S_CFG_COEF)  || (r_state == S_CFG_EXIT);
  assign w_cfg_accept = cfg_start && ((r_state == S_IDLE) || (r_state == S_READY));
  assign w_gap_last   = (r_cnt == CW'(CFG_GAP - 1));
  assign w_to_last    = (r_cnt == CW'(TIMEOUT - 1));
  assign w_coef_last  = (r_idx == r_taps);

`ifdef FIR_SCHED_OVF_SAT_EN
  always_comb begin
    w_cap_data = fir_data_out;
    if (fir_overflow_flag == 2'b01) begin
      w_cap_data = 8'h7F;
    end else if (fir_overflow_flag == 2'b10) begin
      w_cap_data = 8'h80;
    end
  end
`else
  assign w_cap_data = fir_data_out;
`endif

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next                 = r_state;
    s_ready                = 1'b0;
    fir_enable             = 1'b0;
    fir_configuration      = 1'b0;
    fir_config_data_enable = 1'b0;
    fir_data_in            = 8'h00;
    unique case (r_state)
      S_IDLE: begin
        if (cfg_start) w_next = S_CFG_SETUP;
      end
      S_READY: begin
        // A same-cycle cfg_start wins, so the sample must not be acknowledged.
        s_ready = !cfg_start;
        if (cfg_start) begin
          w_next = S_CFG_SETUP;
        end else if (s_valid) begin
          w_next = S_ISSUE;
        end
      end
      S_CFG_SETUP: begin
        fir_configuration = 1'b1;
        if (w_gap_last) w_next = S_CFG_COUNT;
      end
      S_CFG_COUNT: begin
        fir_configuration      = 1'b1;
        fir_config_data_enable = 1'b1;
        fir_data_in            = 8'(r_taps);
        w_next                 = S_CFG_COEF;
      end
      S_CFG_COEF: begin
        fir_configuration      = 1'b1;
        fir_config_data_enable = 1'b1;
        fir_data_in            = r_coef[r_idx];
        if (w_coef_last) w_next = S_CFG_EXIT;
      end
      S_CFG_EXIT: begin
        fir_configuration = 1'b1;
        if (w_gap_last) w_next = S_READY;
      end
      S_ISSUE: begin
        fir_enable  = 1'b1;
        fir_data_in = r_sample;
        w_next      = S_WAIT_DONE;
      end
      S_WAIT_DONE: begin
        if (fir_done) begin
          w_next = S_HOLD;
        end else if (w_to_last) begin
          w_next = S_IDLE;
        end
      end
      S_HOLD: begin
        if (r_ready) w_next = S_GAP;
      end
      S_GAP: begin
        w_next = S_READY;
      end
      default: begin
        w_next = S_IDLE;
      end
    endcase
  end

  // r_cnt counts cycles spent in the current state; it restarts on every transition.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_cnt        <= '0;
      r_idx        <= '0;
      r_taps       <= '0;
      r_sample     <= 8'h00;
      r_res_data   <= 8'h00;
      r_res_flag   <= 2'b00;
      r_configured <= 1'b0;
      r_err        <= 1'b0;
    end else begin
      r_cnt <= (w_next != r_state) ? '0 : r_cnt + 1'b1;
      r_idx <= (r_state == S_CFG_COEF) ? r_idx + 1'b1 : '0;
      if (w_cfg_accept) begin
        r_taps       <= taps_m1;
        r_err        <= 1'b0;
        r_configured <= 1'b0;
      end
      if ((r_state == S_CFG_EXIT) && w_gap_last) begin
        r_configured <= 1'b1;
      end
      if ((r_state == S_READY) && s_valid && s_ready) begin
        r_sample <= s_data;
      end
      if (r_state == S_WAIT_DONE) begin
        if (fir_done) begin
          r_res_data <= w_cap_data;
          r_res_flag <= fir_overflow_flag;
        end else if (w_to_last) begin
          r_err        <= 1'b1;
          r_configured <= 1'b0;
        end
      end
    end
  end

  // Register file is deliberately left unreset; writes are frozen while loading the core.
  always_ff @(posedge clk) begin
    if (coef_we && !w_in_cfg) begin
      r_coef[coef_addr] <= coef_wdata;
    end
  end

  assign r_valid     = (r_state == S_HOLD);
  assign busy        = (r_state != S_IDLE) && (r_state != S_READY);
  assign configured  = r_configured;
  assign err_timeout = r_err;
  assign r_data      = r_res_data;
  assign r_ovf       = r_res_flag;

endmodule
`default_nettype wire
